fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the single-cycle MIPS datapath, directly upstream of the instruction decoder. Holds the program counter, issues word fetches to instruction memory with a req/ack handshake, and latches the returned instruction. It presents the opcode, funct and operand fields to the decoder, then advances the PC using the decoder's `pcmux` selection once the execute side commits the instruction.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be word-aligned.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request; high only in state FETCH.
- `imem_addr`  out  32  fetch address (= `pc`); stable while `imem_req` high.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  latched instruction valid (state HOLD).
- `instr`  out  32  latched instruction.
- `opcode` / `functcode`  out  6 / 6  `instr[31:26]` / `instr[5:0]`.
- `rs`, `rt`, `rd`  out  5 each  `instr[25:21]`, `[20:16]`, `[15:11]`.
- `imm16`  out  16  `instr[15:0]`.
- `pc`  out  32  address of the held instruction.
- `pc_plus4`  out  32  `pc + 4` (link value for JAL).
- `pcmux`  in  2  next-PC select from decoder: 0 seq, 1 jump, 2 jr, 3 branch taken.
- `jr_target`  in  32  register value for JR.
- `commit`  in  1  execute stage is done with the held instruction.
- `fault`  out  1  sticky misaligned-target flag.

## Operation
- States: FETCH, HOLD, HALT.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On `imem_ack`: `instr`<=`imem_rdata`, go to HOLD. Otherwise stay.
- HOLD: `instr_valid`=1; the decoder evaluates `instr` combinationally. On `commit`, `pc`<=next_pc and the block goes to FETCH.
- next_pc (all arithmetic mod 2^32, wrap silently):
  - 0 → `pc_plus4`.
  - 1 → {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}.
  - 2 → `jr_target`.
  - 3 → `pc_plus4` + ({{14{imm16[15]}}, imm16, 2'b00}).
- Misalignment: if next_pc[1:0] ≠ 0 at commit (only possible for pcmux=2):
  - `pc` is not updated.
  - `fault`<=1; go to HALT.
- HALT: no requests; `instr_valid`=0; `commit` and `imem_ack` are ignored. Exit only by reset.
- `imem_ack` outside FETCH is ignored. `commit` outside HOLD is ignored.
- `pcmux` and `jr_target` are sampled only in the commit cycle.

## Timing
- Reset (async assert, applied immediately): `pc`=`RESET_PC`, `instr`=0, state FETCH, `fault`=0. Outputs during reset: `imem_req`=1, `instr_valid`=0, and all field outputs 0.
- First request is visible in the cycle after `rst_n` deasserts. Reset deassertion is synchronised by the top level.
- Ack in cycle N → `instr_valid`=1 in cycle N+1. Commit in cycle M → `imem_req`=1 with the new address in cycle M+1.
- Minimum throughput is 2 cycles per instruction (ack and commit each in their first possible cycle). No ack-in-the-same-cycle bypass.
- `imem_addr` must not change while `imem_req`=1 and `imem_ack`=0. Memory may hold `ack` low indefinitely.
- Reset mid-fetch or mid-hold abandons the instruction. A late `imem_ack` after reset is treated as the ack for `RESET_PC`. The memory must drop outstanding requests on reset.

## Structure
- Shared package `fetch_pkg`:
  - pcmux encodings `PC_SEQ`=0, `PC_JUMP`=1, `PC_JR`=2, `PC_BRANCH`=3.
  - State enum {FETCH, HOLD, HALT}.
  - `RESET_PC` default.
  - The decoder will import the same pcmux encodings.
- Sub-module `next_pc_calc`: combinational next_pc and misalign flag from `pc_plus4`, `instr[25:0]`, `imm16`, `jr_target`, `pcmux`.
- FSM and PC/instr registers live in `fetch_unit`.

## Test plan
- Sequential fetch:
  - Stimulus: reset with `RESET_PC`=0; ack after 0 and after 3 wait cycles; commit with pcmux=0 each time.
  - Required: fetch addresses 0x0, 0x4, 0x8; `imem_addr` stable during waits.
- Branch:
  - Stimulus: `pc`=0x100, `instr`=0x1000FFFE (beq, imm=-2), commit with pcmux=3.
  - Required: next `imem_addr`=0x0FC. Repeat with imm=0x7FFF → 0x20100.
- Jump:
  - Stimulus: `pc`=0x4000_0010, `instr`=0x0800_0040, commit with pcmux=1.
  - Required: next `imem_addr`=0x4000_0100.
- JR:
  - Stimulus: aligned `jr_target`=0x0000_1234_5678 masked to 0x1234_5678, pcmux=2.
  - Required: fetch at 0x1234_5678.
- Misaligned JR:
  - Stimulus: `jr_target`=0x202.
  - Required: `fault`=1; `imem_req` stays 0 thereafter; `pc` unchanged; later commit/ack ignored.
- Wrap-around and reset:
  - Stimulus: `pc`=0xFFFF_FFFC, pcmux=0.
  - Required: next address 0x0.
  - Stimulus: assert `rst_n`=0 while in HOLD.
  - Required: `instr_valid` drops immediately; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select encodings,
// fetch FSM states and the default reset PC.
package fetch_pkg;

  // The decoder drives pcmux with these same encodings.
  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_JUMP   = 2'd1,
    PC_JR     = 2'd2,
    PC_BRANCH = 2'd3
  } pcmux_e;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StHold  = 2'd1,
    StHalt  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Sign-extended word offset of a branch immediate.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch stage, plus a flag raised when
// the selected target is not word-aligned.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr_index,
  input  logic [15:0] imm16,
  input  logic [31:0] jr_target,
  input  logic [1:0]  pcmux,
  output logic [31:0] next_pc,
  output logic        misalign
);

  always_comb begin
    next_pc = pc_plus4;
    unique case (pcmux_e'(pcmux))
      PC_SEQ:    next_pc = pc_plus4;
      PC_JUMP:   next_pc = {pc_plus4[31:28], instr_index, 2'b00};
      PC_JR:     next_pc = jr_target;
      PC_BRANCH: next_pc = pc_plus4 + branch_offset(imm16);
      default:   next_pc = pc_plus4;
    endcase
  end

  // Only a JR target can carry low bits; the other paths are aligned by construction.
  assign misalign = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches words over a req/ack handshake,
// latches the instruction for the decoder and advances the PC on commit.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  functcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  pcmux,
  input  logic [31:0] jr_target,
  input  logic        commit,
  output logic        fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         fault_q, fault_d;

  logic [31:0]  next_pc;
  logic         next_pc_misalign;

  assign pc_plus4 = pc_q + 32'd4;

  next_pc_calc u_next_pc_calc (
    .pc_plus4    (pc_plus4),
    .instr_index (instr_q[25:0]),
    .imm16       (instr_q[15:0]),
    .jr_target   (jr_target),
    .pcmux       (pcmux),
    .next_pc     (next_pc),
    .misalign    (next_pc_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    unique case (state_q)
      StFetch: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StHold;
        end
      end
      StHold: begin
        if (commit) begin
          // A misaligned target freezes the PC at the offending instruction.
          if (next_pc_misalign) begin
            fault_d = 1'b1;
            state_d = StHalt;
          end else begin
            pc_d    = next_pc;
            state_d = StFetch;
          end
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StHalt;
      end
    endcase
  end

  assign imem_req    = (state_q == StFetch);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == StHold);
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign functcode   = instr_q[5:0];
  assign rs          = instr_q[25:21];
  assign rt          = instr_q[20:16];
  assign rd          = instr_q[15:11];
  assign imm16       = instr_q[15:0];
  assign pc          = pc_q;
  assign fault       = fault_q;

endmodule
